// File: rtl/free_list.sv
// Circular free list of physical register indices with per-branch head
// checkpoints for single-cycle mispredict recovery.
module free_list #(
    parameter int PHYS_REG_NUM = 64,
    parameter int ARCH_REG_NUM = 32,
    parameter int BRANCH_NUM   = 4,
    localparam int PW = $clog2(PHYS_REG_NUM),
    localparam int BW = $clog2(BRANCH_NUM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc_req,
    output logic          alloc_ready,
    output logic [PW-1:0] alloc_reg,
    input  logic          reclaim_valid,
    input  logic [PW-1:0] reclaim_reg,
    input  logic          checkpoint_valid,
    output logic [BW-1:0] checkpoint_id,
    output logic          checkpoint_full,
    input  logic          branch_done,
    input  logic          recover_valid,
    input  logic [BW-1:0] recover_id,
    output logic [PW:0]   free_count,
    output logic [PW-1:0] free_tail_pointer,
    output logic          err
);
    localparam int HW = PW + 1;
    localparam int LW = BW + 1;
    localparam logic [HW-1:0] FULL_CNT = HW'(PHYS_REG_NUM);
    localparam logic [LW-1:0] MAX_LIVE = LW'(BRANCH_NUM);

    logic [PW-1:0] ring [PHYS_REG_NUM];
    logic [HW-1:0] slot [BRANCH_NUM];
    logic [HW-1:0] head, tail, head_after;
    logic [BW-1:0] cp_wr, cp_rd, rd_eff, rec_off;
    logic [LW-1:0] cp_live, live_eff;
    logic          grant, reclaim_ok, done_ok, recover_ok, cp_ok;

    assign free_count        = tail - head;
    assign alloc_ready       = (free_count != '0);
    assign alloc_reg         = ring[head[PW-1:0]];
    assign free_tail_pointer = tail[PW-1:0];
    assign checkpoint_id     = cp_wr;
    assign checkpoint_full   = (cp_live == MAX_LIVE);

    // branch_done retires the oldest slot before recover_id is checked against the live window
    assign done_ok    = branch_done && (cp_live != '0);
    assign rd_eff     = cp_rd + BW'(done_ok);
    assign live_eff   = cp_live - LW'(done_ok);
    assign rec_off    = recover_id - rd_eff;
    assign recover_ok = recover_valid && ({1'b0, rec_off} < live_eff);

    assign grant      = alloc_req && alloc_ready && !recover_ok;
    assign reclaim_ok = reclaim_valid && (free_count != FULL_CNT);
    assign cp_ok      = checkpoint_valid && !checkpoint_full && !recover_ok;
    assign head_after = head + HW'(grant);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHYS_REG_NUM; i++)
                ring[i] <= (i < PHYS_REG_NUM - ARCH_REG_NUM) ? PW'(ARCH_REG_NUM + i) : '0;
            for (int i = 0; i < BRANCH_NUM; i++)
                slot[i] <= '0;
            head    <= '0;
            tail    <= HW'(PHYS_REG_NUM - ARCH_REG_NUM);
            cp_wr   <= '0;
            cp_rd   <= '0;
            cp_live <= '0;
            err     <= 1'b0;
        end else begin
            if (reclaim_ok) begin
                ring[tail[PW-1:0]] <= reclaim_reg;
                tail               <= tail + HW'(1);
            end
            cp_rd <= rd_eff;
            if (recover_ok) begin
                head    <= slot[recover_id];
                cp_wr   <= recover_id + BW'(1);
                cp_live <= {1'b0, rec_off} + LW'(1);
            end else begin
                head <= head_after;
                if (cp_ok) begin
                    slot[cp_wr] <= head_after;
                    cp_wr       <= cp_wr + BW'(1);
                    cp_live     <= live_eff + LW'(1);
                end else begin
                    cp_live <= live_eff;
                end
            end
            if ((reclaim_valid && !reclaim_ok) ||
                (checkpoint_valid && checkpoint_full) ||
                (branch_done && !done_ok) ||
                (recover_valid && !recover_ok))
                err <= 1'b1;
        end
    end
endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Circular free list of physical register indices for the out-of-order core.
- Supplies free physical registers to rename, one per cycle.
- Takes back registers released at commit (reclaim_valid/reclaim_reg).
- Snapshots its head pointer per in-flight branch so a mispredict restores the allocation state in one cycle.

Parameters:
PHYS_REG_NUM, 64, physical registers and ring depth; power of two
ARCH_REG_NUM, 32, architectural registers; phys 0..ARCH_REG_NUM-1 mapped at reset
BRANCH_NUM, 4, checkpoint slots; power of two

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
alloc_req  in  1  rename requests one free register this cycle
alloc_ready  out  1  list non-empty (free_count != 0)
alloc_reg  out  log2(PHYS_REG_NUM)  register at head, valid when alloc_ready
reclaim_valid  in  1  commit returns a register
reclaim_reg  in  log2(PHYS_REG_NUM)  returned register index
checkpoint_valid  in  1  allocate a checkpoint for a newly renamed branch
checkpoint_id  out  log2(BRANCH_NUM)  slot the next checkpoint uses (checkpoint write pointer)
checkpoint_full  out  1  all BRANCH_NUM slots live
branch_done  in  1  oldest branch committed; free oldest checkpoint
recover_valid  in  1  mispredict recovery
recover_id  in  log2(BRANCH_NUM)  checkpoint to restore
free_count  out  log2(PHYS_REG_NUM)+1  number of free registers
free_tail_pointer  out  log2(PHYS_REG_NUM)  ring write index, for commit bookkeeping
err  out  1  sticky protocol-violation flag

Behaviour:
- State: ring[PHYS_REG_NUM] of indices.
- Pointers head and tail are log2(PHYS_REG_NUM)+1 bits wide; the MSB is the wrap bit.
- free_count = tail - head, modulo 2^(log2(PHYS_REG_NUM)+1).
- Reset values (asynchronous):
  - ring[i] = ARCH_REG_NUM+i for i < PHYS_REG_NUM-ARCH_REG_NUM; other entries 0.
  - head = 0; tail = PHYS_REG_NUM-ARCH_REG_NUM, so free_count = 32.
  - Checkpoint read/write pointers = 0, live count = 0; err = 0.
  - Resulting outputs: alloc_ready = 1, alloc_reg = 32, free_tail_pointer = 32, checkpoint_full = 0.
- Allocate:
  - grant = alloc_req & alloc_ready.
  - alloc_reg is combinational: ring[head low bits].
  - head increments on the clock edge of a grant.
  - No bypass: a reclaim in the same cycle cannot satisfy an alloc while free_count = 0.
  - alloc_req with alloc_ready = 0 is ignored; nothing changes.
- Reclaim:
  - reclaim_valid writes ring[tail low bits] = reclaim_reg and increments tail; visible next cycle.
  - Reclaim when free_count == PHYS_REG_NUM: write dropped, err set.
- Alloc and reclaim in the same cycle: both apply; free_count unchanged.
- Checkpoint:
  - checkpoint_valid stores slot[checkpoint write pointer] = head after this cycle's grant.
  - The checkpoint write pointer and live count then increment.
  - Used together with alloc_req for a branch that writes a register, so the restore point excludes that branch's own destination register.
  - With checkpoint_full = 1: ignored, err set.
- branch_done: checkpoint read pointer increments, live count decrements. With live count 0: ignored, err set.
- Recover:
  - head = slot[recover_id]; checkpoint write pointer = recover_id+1, so younger checkpoints are discarded.
  - Live count recomputed as write pointer minus read pointer.
  - Any alloc grant and checkpoint_valid in the same cycle are ignored.
  - Reclaim in the same cycle still applies to tail.
  - branch_done in the same cycle still advances the read pointer first.
  - recover_id not live: ignored, err set.
- Wrap-around: all pointers wrap modulo depth, no special case; full vs empty distinguished only by the wrap bit.
- Outputs derive combinationally from registered state only; no input-to-output path except none (alloc_reg is state-only).
- Asserting rst mid-operation returns every register to its reset value immediately.

Test Plan:
- Reset, then alloc_req held 32 cycles -> alloc_reg 32,33,...,63; free_count 0 and alloc_ready 0 at cycle 33; next alloc_req causes no change.
- From empty: reclaim 5 and alloc_req in the same cycle -> no grant; next cycle alloc_ready = 1, alloc_reg = 5, free_count = 1.
- 64 reclaims from reset interleaved with allocs -> tail wraps 63->0 (wrap bit toggles), free_count correct throughout, free_tail_pointer follows the low bits.
- Alloc 3 (32-34); checkpoint with 4th alloc (35) -> slot0 holds head = 4; alloc 2 more; recover_valid, recover_id = 0 -> alloc_reg = 36, free_count = 28, checkpoint_id = 1.
- 4 checkpoints -> checkpoint_full = 1; 5th checkpoint_valid sets err; branch_done -> checkpoint_full = 0, next checkpoint lands in slot 0.
- Reclaim while free_count = 64 -> err = 1, free_count stays 64; assert rst mid-stream -> free_count = 32, err = 0.
